// File: rtl/bcrypt_pkg.sv
// -----------------------------------------------------------------------------
// bcrypt_pkg
// Shared constants and types for the bcrypt datapath blocks.
//   state_t     : Feistel core sequencer states (IDLE, ADDR, CALC, DONE)
//   NUM_ROUNDS  : Blowfish round count (16)
//   P_WORDS     : P-array length in 32-bit words (18)
//   WORD_W      : Blowfish word width (32)
//   P_BITS      : width of the flattened P-array bus (576)
//   p_word()    : extracts P[idx] from the flattened bus, P0 in the MSBs
// -----------------------------------------------------------------------------
package bcrypt_pkg;

    localparam int NUM_ROUNDS = 16;
    localparam int P_WORDS    = 18;
    localparam int WORD_W     = 32;
    localparam int P_BITS     = P_WORDS * WORD_W;
    localparam int ROUND_W    = 4;
    localparam int PIDX_W     = 5;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // P[idx] lives at bits [P_BITS-1-WORD_W*idx -: WORD_W]. Shifting left by
    // whole words brings the wanted word to the top, which avoids a
    // variable-width part-select index.
    function automatic logic [WORD_W-1:0] p_word(input logic [P_BITS-1:0] p_vec,
                                                 input logic [PIDX_W-1:0] idx);
        logic [P_BITS-1:0] shifted;
        shifted = p_vec << (WORD_W * int'(idx));
        return shifted[P_BITS-1 -: WORD_W];
    endfunction

endpackage

// File: rtl/blowfish_f.sv
// -----------------------------------------------------------------------------
// blowfish_f
// Blowfish round function, purely combinational:
//   F = ((S1 + S2) ^ S3) + S4, additions modulo 2^32.
// Ports:
//   s1_i..s4_i : S-box words selected by the four bytes of xL (MSB byte -> s1)
//   f_o        : round function result
// -----------------------------------------------------------------------------
module blowfish_f
    import bcrypt_pkg::*;
(
    input  logic [WORD_W-1:0] s1_i,
    input  logic [WORD_W-1:0] s2_i,
    input  logic [WORD_W-1:0] s3_i,
    input  logic [WORD_W-1:0] s4_i,
    output logic [WORD_W-1:0] f_o
);

    logic [WORD_W-1:0] sum12;
    logic [WORD_W-1:0] mix3;

    assign sum12 = s1_i + s2_i;
    assign mix3  = sum12 ^ s3_i;
    assign f_o   = mix3 + s4_i;

endmodule

// File: rtl/blowfish_feistel.sv
// -----------------------------------------------------------------------------
// blowfish_feistel
// 16-round Blowfish encryption of one 64-bit block, reading the four S-box
// SRAMs (1-cycle read latency) two cycles per round: ADDR presents the xL
// bytes, CALC consumes the returned words.
// Ports:
//   clk, reset_l        : clock, asynchronous active-low reset
//   start               : begin encryption (only honoured in IDLE)
//   L_in, R_in          : input block halves, captured on accepted start
//   p                   : flattened P-array, P0 in the MSBs, stable while busy
//   s1_out..s4_out      : S-box read data
//   s1_addr..s4_addr    : S-box read addresses (0 outside ADDR)
//   s1_cs_l..s4_cs_l    : S-box chip selects, low only in ADDR
//   s1_we_l..s4_we_l    : S-box write enables, permanently inactive
//   resultL, resultR    : encrypted block, held until the next accepted start
//   busy                : high from the cycle after start through DONE
//   done                : one-cycle pulse when the result is valid
// -----------------------------------------------------------------------------
module blowfish_feistel
    import bcrypt_pkg::*;
(
    input  logic              clk,
    input  logic              reset_l,
    input  logic              start,
    input  logic [WORD_W-1:0] L_in,
    input  logic [WORD_W-1:0] R_in,
    input  logic [P_BITS-1:0] p,
    input  logic [WORD_W-1:0] s1_out,
    input  logic [WORD_W-1:0] s2_out,
    input  logic [WORD_W-1:0] s3_out,
    input  logic [WORD_W-1:0] s4_out,
    output logic [7:0]        s1_addr,
    output logic [7:0]        s2_addr,
    output logic [7:0]        s3_addr,
    output logic [7:0]        s4_addr,
    output logic              s1_cs_l,
    output logic              s2_cs_l,
    output logic              s3_cs_l,
    output logic              s4_cs_l,
    output logic              s1_we_l,
    output logic              s2_we_l,
    output logic              s3_we_l,
    output logic              s4_we_l,
    output logic [WORD_W-1:0] resultL,
    output logic [WORD_W-1:0] resultR,
    output logic              busy,
    output logic              done
);

    state_t               state_q, state_d;
    logic [WORD_W-1:0]    xl_q, xl_d;
    logic [WORD_W-1:0]    xr_q, xr_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [WORD_W-1:0]    resl_q, resl_d;
    logic [WORD_W-1:0]    resr_q, resr_d;

    logic [WORD_W-1:0]    f_val;
    logic [WORD_W-1:0]    new_r;
    logic [PIDX_W-1:0]    next_pidx;
    logic                 in_addr;

    blowfish_f u_f (
        .s1_i (s1_out),
        .s2_i (s2_out),
        .s3_i (s3_out),
        .s4_i (s4_out),
        .f_o  (f_val)
    );

    assign new_r     = xr_q ^ f_val;
    assign next_pidx = {1'b0, round_q} + PIDX_W'(1);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            xl_q    <= '0;
            xr_q    <= '0;
            round_q <= '0;
            resl_q  <= '0;
            resr_q  <= '0;
        end else begin
            state_q <= state_d;
            xl_q    <= xl_d;
            xr_q    <= xr_d;
            round_q <= round_d;
            resl_q  <= resl_d;
            resr_q  <= resr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xl_d    = xl_q;
        xr_d    = xr_q;
        round_d = round_q;
        resl_d  = resl_q;
        resr_d  = resr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    xl_d    = L_in ^ p_word(p, PIDX_W'(0));
                    xr_d    = R_in;
                    round_d = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                state_d = CALC;
            end
            CALC: begin
                if (round_q != LAST_ROUND) begin
                    // Swap halves and pre-whiten the next round's left half.
                    xl_d    = new_r ^ p_word(p, next_pidx);
                    xr_d    = xl_q;
                    round_d = round_q + ROUND_W'(1);
                    state_d = ADDR;
                end else begin
                    // Last round: undo the swap and apply P16/P17 whitening.
                    resl_d  = xl_q ^ p_word(p, PIDX_W'(P_WORDS - 1));
                    resr_d  = new_r ^ p_word(p, PIDX_W'(P_WORDS - 2));
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM interface is driven straight from state so the read is presented
    // in ADDR and the data is consumed exactly one cycle later in CALC.
    assign in_addr = (state_q == ADDR);

    assign s1_addr = in_addr ? xl_q[31:24] : 8'h00;
    assign s2_addr = in_addr ? xl_q[23:16] : 8'h00;
    assign s3_addr = in_addr ? xl_q[15:8]  : 8'h00;
    assign s4_addr = in_addr ? xl_q[7:0]   : 8'h00;

    assign s1_cs_l = ~in_addr;
    assign s2_cs_l = ~in_addr;
    assign s3_cs_l = ~in_addr;
    assign s4_cs_l = ~in_addr;

    assign s1_we_l = 1'b1;
    assign s2_we_l = 1'b1;
    assign s3_we_l = 1'b1;
    assign s4_we_l = 1'b1;

    assign resultL = resl_q;
    assign resultR = resr_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule
